video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the display path. Replaces the bare x/y pixel counter with a full horizontal/vertical timing chain: active, front porch, sync and back porch intervals per axis, programmable sync polarity, an enable for pixel-clock division, line/frame strobes and a frame counter. Drives the framebuffer read address (x, y), the DAC blanking input (active) and the monitor sync pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CW, 11, counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise must each be ≤ 2^CW
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  pixel advance qualifier; counters step only when high
- x  out  CW  current horizontal count, 0..H_TOTAL-1
- y  out  CW  current vertical count, 0..V_TOTAL-1
- active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- hsync  out  1  horizontal sync at HS_POL polarity
- vsync  out  1  vertical sync at VS_POL polarity
- line_start  out  1  single-cycle strobe, x == 0 and enable
- frame_start  out  1  single-cycle strobe, x == 0, y == 0 and enable
- frame_count  out  8  completed-frame counter

## Operation
- Two registered counters, h and v; x = h, y = v directly.
- On clock edge with enable=1: if h == H_TOTAL-1, h <= 0 and (v == V_TOTAL-1 ? v <= 0 : v <= v+1); else h <= h+1, v holds.
- enable=0: h, v, frame_count hold; line_start, frame_start forced 0; level outputs keep decoding held counts.
- Horizontal interval order per line: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical identical in lines.
- hsync = HS_POL when h in sync window, else ~HS_POL. vsync = VS_POL when v in vertical sync window, else ~VS_POL. vsync is a function of v only (changes on line boundary, h == 0).
- frame_count increments by 1 (mod 256) on the enabled edge where h == H_TOTAL-1 and v == V_TOTAL-1.
- Compare arithmetic at CW bits; interval bounds are elaboration-time constants. Zero-width porch parameters legal (interval empty); H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE ≥ 1.

## Timing
- All outputs are combinational decodes of h, v, frame_count registers and enable: zero latency, all aligned to the same cycle as x, y.
- Reset (asynchronous, any time, including mid-line): h = 0, v = 0, frame_count = 0 immediately. Resulting outputs while reset held: x = 0, y = 0, active = 1, hsync = ~HS_POL, vsync = ~VS_POL, line_start = frame_start = enable.
- First enabled cycle after reset release is pixel (0,0) with frame_start high.
- With enable tied high: line period H_TOTAL cycles, frame period H_TOTAL·V_TOTAL cycles; line_start/frame_start exactly one cycle per line/frame.
- With enable pulsed 1-in-N: each pixel holds N cycles; strobes remain one cycle wide (the enabled cycle).

## Configuration
- VIDEO_TIMING_FRAME_CNT_EN defined: frame_count register and increment logic present as above.
- Not defined: no frame counter register; frame_count tied to 8'd0. All other behaviour unchanged.

## Test plan
- Small config H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), enable=1, reset released -> x cycles 0..7, y steps every 8 cycles, back to (0,0) at cycle 48; frame_start high at cycles 0 and 48 only.
- Same config, HS_POL=0 -> hsync low exactly at x = 5,6 each line; vsync low exactly for y = 4 (cycles 32..39); active high only for x<4, y<3 (12 cycles/frame).
- Polarity flip HS_POL=1, VS_POL=1 -> hsync/vsync waveforms are exact inversions of previous scenario.
- enable toggled 1,0,1,0... -> counters advance every other cycle, frame period 96 cycles, line_start/frame_start one cycle wide and never high while enable=0.
- Reset asserted asynchronously at x=6, y=2 (mid-sync) -> x, y, frame_count go to 0 before next clock edge; hsync returns to ~HS_POL; frame restarts cleanly from (0,0).
- Run 257 frames with VIDEO_TIMING_FRAME_CNT_EN defined -> frame_count reads 1 after first frame, wraps 255 -> 0 at frame 256, reads 1 at frame 257; undefined -> frame_count constant 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with horizontal/vertical counters,
// active/porch/sync decoding, programmable sync polarity, enable-qualified
// stepping, line/frame strobes and an optional completed-frame counter.
// Optional feature macro: VIDEO_TIMING_FRAME_CNT_EN (frame counter present when defined).
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Terminal counts fit in CW bits because each total is at most 2^CW.
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Window bounds carry one extra bit so an interval ending exactly at
    // 2^CW does not wrap to zero.
    localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG    = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG    = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW:0]   h_ext, v_ext;
    logic          h_wrap;
    logic          hs_win, vs_win;

    assign h_wrap = (h_q == H_LAST);
    assign h_ext  = {1'b0, h_q};
    assign v_ext  = {1'b0, v_q};

    // Next-state for the raster counters: h steps each enabled cycle, v on h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (enable) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Raster counter registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    // Completed-frame count advances on the enabled edge that leaves the last pixel.
    always_comb begin
        fc_d = fc_q;
        if (enable && h_wrap && (v_q == V_LAST)) begin
            fc_d = fc_q + 8'd1;
        end
    end

    // Frame counter register, wraps modulo 256.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fc_q <= 8'd0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_count = fc_q;
`else
    assign frame_count = 8'd0;
`endif

    assign hs_win = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs_win = (v_ext >= VS_BEG) && (v_ext < VS_END);

    assign x           = h_q;
    assign y           = v_q;
    assign active      = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hsync       = hs_win ? HS_POL : ~HS_POL;
    assign vsync       = vs_win ? VS_POL : ~VS_POL;
    assign line_start  = enable && (h_q == '0);
    assign frame_start = enable && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a tiny 8x6 raster (CW at its minimum
// of 3 bits), with a second instance of inverted sync polarity.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] x, y, x2, y2;
    logic       active, hsync, vsync, line_start, frame_start;
    logic       active2, hsync2, vsync2, line_start2, frame_start2;
    logic [7:0] frame_count, frame_count2;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(3)
    ) u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(3)
    ) u_inv (
        .clock(clock), .reset(reset), .enable(enable),
        .x(x2), .y(y2), .active(active2), .hsync(hsync2), .vsync(vsync2),
        .line_start(line_start2), .frame_start(frame_start2),
        .frame_count(frame_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for pixel (xe, ye): hsync low at x=5,6; vsync low at y=4;
    // active for x<4, y<3.
    task automatic check_pix(input int xe, input int ye, input logic en, input int frames);
        chk("x", 32'(x), 32'(xe));
        chk("y", 32'(y), 32'(ye));
        chk("active", 32'(active), 32'(xe < 4 && ye < 3));
        chk("hsync", 32'(hsync), 32'(!(xe == 5 || xe == 6)));
        chk("vsync", 32'(vsync), 32'(ye != 4));
        chk("line_start", 32'(line_start), 32'(en && xe == 0));
        chk("frame_start", 32'(frame_start), 32'(en && xe == 0 && ye == 0));
        chk("hsync_inv", 32'(hsync2), 32'(xe == 5 || xe == 6));
        chk("vsync_inv", 32'(vsync2), 32'(ye == 4));
        chk("frame_count", 32'(frame_count), FC_ON ? 32'(frames % 256) : 32'd0);
    endtask

    initial begin
        int act_n, hs_n, vs_n, p;

        // Reset held, enable low then high: outputs decode (0,0).
        #12;
        check_pix(0, 0, 1'b0, 0);
        enable = 1'b1;
        #1;
        check_pix(0, 0, 1'b1, 0);

        // Free-running, one full frame plus the wrap back to (0,0).
        @(posedge clock); #1;
        reset = 1'b0;
        act_n = 0; hs_n = 0; vs_n = 0;
        for (int n = 0; n <= 48; n++) begin
            @(negedge clock);
            check_pix(n % 8, (n / 8) % 6, 1'b1, n / 48);
            if (n < 48) begin
                act_n += int'(active);
                hs_n  += int'(!hsync);
                vs_n  += int'(!vsync);
            end
        end
        chk("active_per_frame", 32'(act_n), 32'd12);
        chk("hsync_low_per_frame", 32'(hs_n), 32'd12);
        chk("vsync_low_per_frame", 32'(vs_n), 32'd8);

        // Enable toggling 1,0,1,0: one pixel per two cycles, 96-cycle frame.
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k <= 97; k++) begin
            enable = (k % 2 == 0);
            @(negedge clock);
            p = (k + 1) / 2;
            check_pix(p % 8, (p / 8) % 6, enable, p / 48);
            @(posedge clock); #1;
        end

        // Long run for the frame counter wrap: 257 frames.
        reset = 1'b1;
        enable = 1'b1;
        #1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int n = 0; n <= 257 * 48; n++) begin
            @(negedge clock);
            if (n % 48 == 0) check_pix(0, 0, 1'b1, n / 48);
        end

        // Advance to x=6, y=2 (mid-sync) and reset asynchronously.
        for (int n = 1; n <= 22; n++) @(negedge clock);
        check_pix(6, 2, 1'b1, 257);
        #2;
        reset = 1'b1;
        #1;
        check_pix(0, 0, 1'b1, 0);

        // Clean restart from (0,0).
        @(posedge clock); #1;
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check_pix(n % 8, n / 8, 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
